periph_bus_arbiter: RTL and testbench
=====================================

# periph_bus_arbiter

Two-master arbiter and sequencer for the memory-mapped peripheral bus (timer, LED, switch, 7-segment, UART registers at 0x4000_0000 and up). Master 0 is the CPU data port. Master 1 is a secondary requester, such as a UART command engine or a debug port. The block grants the bus round-robin, registers the winning command onto the peripheral bus for exactly one access cycle, captures read data, and returns a one-cycle acknowledge. An optional lock gives one master atomic read-modify-write sequences, bounded by a timeout.

## Interface
- LOCK_TIMEOUT, 16: maximum IDLE cycles a lock may hold the bus while its owner has no request.
- PERIPH_BASE, 4'h4: required value of addr[31:28] for a legal access.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_req / m1_req  in  1  request. High in an IDLE cycle means a new transaction.
- m0_wr / m1_wr  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_lock / m1_lock  in  1  keep the grant for this master's next request.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  read data, valid while ack is high.
- m0_err / m1_err  out  1  address outside the peripheral window, valid with ack.
- p_rd, p_wr  out  1  peripheral strobes.
- p_addr, p_wdata  out  32  peripheral command.
- p_rdata  in  32  combinational peripheral read data.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states:
  - IDLE → ACCESS: on any eligible request.
  - ACCESS → ACK: always.
  - ACK → IDLE: always.
- Arbitration is evaluated in IDLE only. Eligibility and winner:
  - Lock active for master N: only mN_req is eligible.
  - Otherwise, with both requesting, grant the master that was not granted last (last_gnt register, reset value 0, so master 1 wins the first tie).
  - With a single requester, grant it.
- On grant, register addr, wdata and wr into the p_* outputs.
- Legal access (addr[31:28]==PERIPH_BASE):
  - In ACCESS, p_rd = ~wr and p_wr = wr for exactly one cycle.
  - For a read, capture p_rdata into the granted master's rdata register at the end of ACCESS.
  - For a write, rdata = 0.
- Illegal address:
  - p_rd and p_wr stay 0 in ACCESS.
  - Return err = 1 and rdata = 0.
- ACK state: assert ack (and err if set) to the granted master only, for one cycle. p_rd and p_wr are 0.
- Lock behaviour:
  - Lock is sampled with the grant. If mN_lock = 1 at grant, lock_owner = N after ACK.
  - A later grant to the owner with lock = 0 releases it.
  - In IDLE with lock held and the owner not requesting, a timeout counter increments. When it reaches LOCK_TIMEOUT, the lock is forcibly released and the counter cleared. The counter clears on every grant.
- Masters must hold req, addr, wdata, wr and lock stable from assertion until ack. Masters must deassert req in the cycle after ack unless issuing a new transaction.

## Timing
- Reset values: all outputs 0, FSM IDLE, last_gnt 0, lock cleared, counter 0.
- Latency: request present in IDLE cycle k → peripheral strobe in cycle k+1 → ack in cycle k+2.
- Throughput: one transaction per 3 cycles. Back-to-back requests are accepted in the IDLE cycle after ACK.
- Reset mid-transaction (ACCESS or ACK): outputs drop immediately. No ack is issued and the transaction is lost.
- Simultaneous lock release and timeout: release wins, counter clears.
- A request that changes while not granted is legal. Only the value in the granting IDLE cycle counts.

## Structure
- Shared package: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2), PERIPH_BASE, peripheral address constants 0x4000_0000–0x4000_0028.
- One natural sub-module: rr_pick2, the 2-way round-robin/lock selector, purely combinational. The FSM and datapath stay in the top module.

## Test plan
- Single read: m0 reads 0x40000010 with p_rdata = 0x000000A5 → p_rd in cycle k+1, m0_ack with m0_rdata = 0xA5 in cycle k+2, m1_ack stays 0.
- Contention: m0 and m1 both request writes continuously → grants alternate m1, m0, m1, m0, with one p_wr per 3 cycles and the correct wdata each time.
- Illegal address: m1 reads 0x00001000 → no p_rd or p_wr, m1_ack and m1_err = 1, m1_rdata = 0.
- Lock RMW:
  - m0 reads TCON with lock = 1 while m1 requests continuously → m0's following write is granted before m1.
  - That write with lock = 0 releases the lock, and m1 is granted next.
- Lock timeout: m0 holds lock and then stays idle for LOCK_TIMEOUT = 16 cycles while m1 requests → m1 is granted immediately after the 16th idle cycle.
- Reset during ACCESS: assert reset in the p_wr cycle → p_wr and busy go 0 asynchronously, no ack follows, and the next request after release completes normally.

Source files
------------

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared constants and types for the two-master peripheral bus arbiter.
package periph_bus_arbiter_pkg;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic [3:0]  PERIPH_BASE_DEF  = 4'h4;
  localparam int unsigned LOCK_TIMEOUT_DEF = 16;

  // Peripheral register map
  localparam logic [31:0] ADDR_TH       = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL       = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON     = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED      = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH   = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGITS   = 32'h4000_0014;
  localparam logic [31:0] ADDR_UART_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_UART_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_UART_CON = 32'h4000_0020;
  localparam logic [31:0] ADDR_UART_BAUD = 32'h4000_0024;
  localparam logic [31:0] ADDR_SYSTICK  = 32'h4000_0028;

  // One master's command as seen at the arbiter inputs
  typedef struct packed {
    logic        wr;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  // True when the top address nibble selects the peripheral window
  function automatic logic in_periph_window(input logic [3:0] addr_hi,
                                            input logic [3:0] base);
    return addr_hi == base;
  endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_pick2.sv
// Two-way round-robin selector with lock override; purely combinational.
module rr_pick2
  import periph_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic lock_active,
  input  logic lock_owner,
  input  logic last_gnt,
  output logic grant_valid,
  output logic grant_id
);

  // A held lock hides the other master; otherwise ties go to whoever lost last time
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (lock_active) begin
      grant_valid = lock_owner ? req1 : req0;
      grant_id    = lock_owner;
    end else if (req0 && req1) begin
      grant_valid = 1'b1;
      grant_id    = ~last_gnt;
    end else if (req0) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master peripheral bus arbiter: grants, issues one registered access,
// returns a one-cycle ack with captured read data, supports a timed lock.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | arbitrate; lock timeout counter runs here
// ACCESS  | p_rd/p_wr strobe for one cycle; read data captured at end
// ACK     | ack (and err) to the granted master; lock state updated
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter logic [3:0]  PERIPH_BASE  = PERIPH_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        p_rd,
  output logic        p_wr,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  input  logic [31:0] p_rdata,
  output logic        busy
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  logic [1:0]       state;
  logic             last_gnt;
  logic             lock_active;
  logic             lock_owner;
  logic [CNT_W-1:0] lock_idle_cnt;

  logic             gnt_id;
  logic             cap_wr;
  logic             cap_lock;
  logic             cap_legal;

  logic             pick_valid;
  logic             pick_id;
  logic             grant;
  logic             owner_req;
  logic             sel_legal;
  bus_cmd_t         m0_cmd;
  bus_cmd_t         m1_cmd;
  bus_cmd_t         sel_cmd;

  rr_pick2 u_pick (
    .req0        (m0_req),
    .req1        (m1_req),
    .lock_active (lock_active),
    .lock_owner  (lock_owner),
    .last_gnt    (last_gnt),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  assign m0_cmd    = {m0_wr, m0_lock, m0_addr, m0_wdata};
  assign m1_cmd    = {m1_wr, m1_lock, m1_addr, m1_wdata};
  assign sel_cmd   = pick_id ? m1_cmd : m0_cmd;
  assign sel_legal = in_periph_window(sel_cmd.addr[31:28], PERIPH_BASE);
  assign grant     = (state == ST_IDLE) && pick_valid;
  assign owner_req = lock_owner ? m1_req : m0_req;
  assign busy      = (state != ST_IDLE);

  // Fixed three-phase sequence once a request is granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (pick_valid) state <= ST_ACCESS;
        ST_ACCESS: state <= ST_ACK;
        ST_ACK:    state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Register the winning command onto the bus; strobes only for legal addresses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_rd      <= 1'b0;
      p_wr      <= 1'b0;
      p_addr    <= '0;
      p_wdata   <= '0;
      gnt_id    <= 1'b0;
      last_gnt  <= 1'b0;
      cap_wr    <= 1'b0;
      cap_lock  <= 1'b0;
      cap_legal <= 1'b0;
    end else begin
      p_rd <= 1'b0;
      p_wr <= 1'b0;
      if (grant) begin
        p_rd      <= sel_legal & ~sel_cmd.wr;
        p_wr      <= sel_legal & sel_cmd.wr;
        p_addr    <= sel_cmd.addr;
        p_wdata   <= sel_cmd.wdata;
        gnt_id    <= pick_id;
        last_gnt  <= pick_id;
        cap_wr    <= sel_cmd.wr;
        cap_lock  <= sel_cmd.lock;
        cap_legal <= sel_legal;
      end
    end
  end

  // Capture the response at the end of ACCESS so it is presented during ACK
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      if (state == ST_ACCESS) begin
        if (gnt_id) begin
          m1_ack   <= 1'b1;
          m1_err   <= ~cap_legal;
          m1_rdata <= (cap_legal && !cap_wr) ? p_rdata : 32'h0;
        end else begin
          m0_ack   <= 1'b1;
          m0_err   <= ~cap_legal;
          m0_rdata <= (cap_legal && !cap_wr) ? p_rdata : 32'h0;
        end
      end
    end
  end

  // Lock ownership follows the lock bit of each completed grant; an idle
  // owner loses it after LOCK_TIMEOUT IDLE cycles without a request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active   <= 1'b0;
      lock_owner    <= 1'b0;
      lock_idle_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (grant) begin
        lock_idle_cnt <= '0;
      end else if (lock_active && !owner_req) begin
        if (lock_idle_cnt == CNT_LAST) begin
          lock_active   <= 1'b0;
          lock_idle_cnt <= '0;
        end else begin
          lock_idle_cnt <= lock_idle_cnt + 1'b1;
        end
      end
    end else if (state == ST_ACK) begin
      lock_active <= cap_lock;
      lock_owner  <= gnt_id;
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: expected strobes and responses are
// queued when stimulus is issued and popped when the DUT produces them.
module tb_periph_bus_arbiter;

  localparam logic [31:0] A_TCON     = 32'h4000_0008;
  localparam logic [31:0] A_LED      = 32'h4000_000C;
  localparam logic [31:0] A_SWITCH   = 32'h4000_0010;
  localparam logic [31:0] A_DIGITS   = 32'h4000_0014;
  localparam logic [31:0] A_UART_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m0_lock, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_lock, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        p_rd, p_wr, busy;
  logic [31:0] p_addr, p_wdata, p_rdata;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } strobe_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  strobe_t sq[$];
  resp_t   aq0[$];
  resp_t   aq1[$];
  strobe_t mon_s;
  resp_t   mon_r;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_strobe_cyc = -1;
  int last_ack_cyc    = -1;
  bit gap_on = 0;
  bit gap_ref_valid = 0;
  int gap_ref = 0;

  periph_bus_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_lock  (m0_lock),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m0_err   (m0_err),
    .m1_req   (m1_req),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_lock  (m1_lock),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .m1_err   (m1_err),
    .p_rd     (p_rd),
    .p_wr     (p_wr),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral read model: SWITCH returns 0xA5, everything else ~addr
  function automatic logic [31:0] periph_data(input logic [31:0] a);
    if (a == 32'h4000_0010) return 32'h0000_00A5;
    return ~a;
  endfunction

  assign p_rdata = periph_data(p_addr);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_strobe(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    strobe_t s;
    s.wr = wr; s.addr = addr; s.wdata = wdata;
    sq.push_back(s);
  endtask

  // Issue one transaction from master id, wait for its ack, then release req
  task automatic m_issue(input logic id, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic lock, output int t_issue);
    resp_t r;
    bit seen;
    seen = 0;
    r.err   = (addr[31:28] != 4'h4);
    r.rdata = (!r.err && !wr) ? periph_data(addr) : 32'h0;
    if (id) begin
      aq1.push_back(r);
      m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
    end else begin
      aq0.push_back(r);
      m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
    end
    t_issue = cyc;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((id ? m1_ack : m0_ack) === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check_val(id ? "m1_ack_timeout" : "m0_ack_timeout", {31'h0, seen}, 32'h1);
    @(posedge clk); #1;
    if (id) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  // Monitor: compare every strobe and ack against the scoreboard queues
  always @(negedge clk) begin
    if (!gap_on) gap_ref_valid = 0;
    if (reset === 1'b0) begin
      if (p_rd || p_wr) begin
        check_val("busy_in_access", {31'h0, busy}, 32'h1);
        if (sq.size() == 0) begin
          check_val("strobe_unexpected", {30'h0, p_rd, p_wr}, 32'h0);
        end else begin
          mon_s = sq.pop_front();
          check_val("p_wr", {31'h0, p_wr}, {31'h0, mon_s.wr});
          check_val("p_rd", {31'h0, p_rd}, {31'h0, ~mon_s.wr});
          check_val("p_addr", p_addr, mon_s.addr);
          if (mon_s.wr) check_val("p_wdata", p_wdata, mon_s.wdata);
        end
        if (gap_on && gap_ref_valid) check_val("strobe_gap", cyc - gap_ref, 32'd3);
        gap_ref = cyc;
        gap_ref_valid = 1;
        last_strobe_cyc = cyc;
      end
      if (m0_ack || m1_ack) begin
        check_val("ack_onehot", {31'h0, m0_ack & m1_ack}, 32'h0);
        check_val("strobe_in_ack", {31'h0, p_rd | p_wr}, 32'h0);
        last_ack_cyc = cyc;
      end
      if (m0_ack) begin
        if (aq0.size() == 0) begin
          check_val("m0_ack_unexpected", {31'h0, m0_ack}, 32'h0);
        end else begin
          mon_r = aq0.pop_front();
          check_val("m0_err", {31'h0, m0_err}, {31'h0, mon_r.err});
          check_val("m0_rdata", m0_rdata, mon_r.rdata);
        end
      end
      if (m1_ack) begin
        if (aq1.size() == 0) begin
          check_val("m1_ack_unexpected", {31'h0, m1_ack}, 32'h0);
        end else begin
          mon_r = aq1.pop_front();
          check_val("m1_err", {31'h0, m1_err}, {31'h0, mon_r.err});
          check_val("m1_rdata", m1_rdata, mon_r.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, t1, t2, a;
    reset = 1'b1;
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0; m0_lock = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_strobes", {30'h0, p_rd, p_wr}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rst_p_addr", p_addr, 32'h0);
    check_val("rst_p_wdata", p_wdata, 32'h0);
    check_val("rst_acks", {28'h0, m0_ack, m1_ack, m0_err, m1_err}, 32'h0);
    check_val("rst_m0_rdata", m0_rdata, 32'h0);
    check_val("rst_m1_rdata", m1_rdata, 32'h0);

    // Single read with latency check
    push_strobe(1'b0, A_SWITCH, 32'h0);
    m_issue(1'b0, 1'b0, A_SWITCH, 32'h0, 1'b0, t);
    check_val("rd_strobe_lat", last_strobe_cyc - t, 32'd1);
    check_val("rd_ack_lat", last_ack_cyc - t, 32'd2);
    repeat (2) @(posedge clk);
    #1;

    // Contention: first tie goes to m1, then strict alternation
    push_strobe(1'b1, A_DIGITS, 32'h0000_0033);
    push_strobe(1'b1, A_LED,    32'h0000_0011);
    push_strobe(1'b1, A_DIGITS, 32'h0000_0044);
    push_strobe(1'b1, A_LED,    32'h0000_0022);
    gap_on = 1;
    fork
      begin
        m_issue(1'b0, 1'b1, A_LED, 32'h0000_0011, 1'b0, t0);
        m_issue(1'b0, 1'b1, A_LED, 32'h0000_0022, 1'b0, t0);
      end
      begin
        m_issue(1'b1, 1'b1, A_DIGITS, 32'h0000_0033, 1'b0, t1);
        m_issue(1'b1, 1'b1, A_DIGITS, 32'h0000_0044, 1'b0, t1);
      end
    join
    gap_on = 0;
    repeat (2) @(posedge clk);
    #1;

    // Illegal address from m1: no strobe, err with zero data
    m_issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, t);
    check_val("illegal_ack_lat", last_ack_cyc - t, 32'd2);
    repeat (2) @(posedge clk);
    #1;

    // Locked read-modify-write by m0 while m1 keeps requesting
    push_strobe(1'b0, A_TCON, 32'h0);
    push_strobe(1'b1, A_TCON, 32'h0000_1234);
    push_strobe(1'b1, A_LED,  32'h0000_0077);
    gap_on = 1;
    fork
      begin
        m_issue(1'b0, 1'b0, A_TCON, 32'h0, 1'b1, t0);
        m_issue(1'b0, 1'b1, A_TCON, 32'h0000_1234, 1'b0, t0);
      end
      begin
        @(posedge clk); #1;
        m_issue(1'b1, 1'b1, A_LED, 32'h0000_0077, 1'b0, t2);
      end
    join
    gap_on = 0;
    repeat (2) @(posedge clk);
    #1;

    // Lock timeout: m0 locks then goes quiet, m1 waits out 16 idle cycles
    push_strobe(1'b0, A_TCON, 32'h0);
    push_strobe(1'b1, A_DIGITS, 32'h0000_CAFE);
    m_issue(1'b0, 1'b0, A_TCON, 32'h0, 1'b1, t);
    a = last_ack_cyc;
    m_issue(1'b1, 1'b1, A_DIGITS, 32'h0000_CAFE, 1'b0, t);
    check_val("lock_timeout_lat", last_strobe_cyc - a, 32'd18);
    repeat (2) @(posedge clk);
    #1;

    // Reset while the write strobe is on the bus
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = A_LED; m0_wdata = 32'h0000_DEAD; m0_lock = 1'b0;
    @(posedge clk); #1;
    check_val("pre_rst_p_wr", {31'h0, p_wr}, 32'h1);
    check_val("pre_rst_busy", {31'h0, busy}, 32'h1);
    #2;
    reset = 1'b1;
    m0_req = 1'b0;
    #1;
    check_val("mid_rst_p_wr", {31'h0, p_wr}, 32'h0);
    check_val("mid_rst_busy", {31'h0, busy}, 32'h0);
    check_val("mid_rst_p_addr", p_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    push_strobe(1'b0, A_UART_CON, 32'h0);
    m_issue(1'b0, 1'b0, A_UART_CON, 32'h0, 1'b0, t);
    check_val("post_rst_ack_lat", last_ack_cyc - t, 32'd2);
    repeat (3) @(posedge clk);
    #1;

    check_val("strobe_q_left", sq.size(), 32'd0);
    check_val("ack0_q_left", aq0.size(), 32'd0);
    check_val("ack1_q_left", aq1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
